// File: rtl/ipdb_common_hs_pkg.sv
// ipdb_common_hs_pkg: shared handshake state type and sizing helper for both ends of the toggle handshake.
package ipdb_common_hs_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } hs_state_t;

    // Width of a counter that must hold 0..t, never narrower than one bit.
    function automatic int cnt_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/ipdb_common_sync.sv
// ipdb_common_sync: two-flop synchronizer for a single asynchronous bit, X/Z resolved to 0 at the first stage.
module ipdb_common_sync (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= (d_i === 1'b1);
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ipdb_common_hs_src.sv
// ipdb_common_hs_src: launching end of a toggle handshake; holds a word on data_o, toggles req_o and
// waits for the synchronized ack toggle to match, with an optional sticky timeout flag.
module ipdb_common_hs_src
    import ipdb_common_hs_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] data_o,
    output logic              req_o,
    input  logic              ack_i,
    output logic              done_o,
    output logic              err_o
);

    localparam int              CNT_W   = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    hs_state_t         state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              req_q, req_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              ack_s;

    ipdb_common_sync u_ack_sync (
        .clk_i     (clk_i),
        .reset_n_i (~reset_i),
        .d_i       (ack_i),
        .q_o       (ack_s)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (valid_i) begin
                data_d  = data_i;
                req_d   = ~req_q;
                cnt_d   = '0;
                state_d = WAIT;
            end
        end else begin
            if (ack_s == req_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            // The handshake is never abandoned on timeout: leaving WAIT early would desync the toggles.
            if (TIMEOUT_CYC > 0) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                err_d = err_q | (cnt_d == CNT_MAX);
            end
        end
    end

    assign ready_o = (state_q == IDLE);
    assign data_o  = data_q;
    assign req_o   = req_q;
    assign done_o  = done_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_ipdb_common_hs_src.sv
// tb_ipdb_common_hs_src: randomized and directed stimulus against a timestamp-based model of the handshake.
module tb_ipdb_common_hs_src;

    localparam int DW    = 8;
    localparam int TO    = 10;
    localparam int NEVER = 32'h7fff_ffff;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid = 1'b0;
    logic [DW-1:0] din = '0;
    logic          ready, req, done, err;
    logic [DW-1:0] dout;
    logic          loop_en = 1'b0;
    logic          ack_man = 1'b0;
    logic          ack;

    assign ack = loop_en ? req : ack_man;

    always #5 clk = ~clk;

    ipdb_common_hs_src #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .valid_i (valid),
        .data_i  (din),
        .ready_o (ready),
        .data_o  (dout),
        .req_o   (req),
        .ack_i   (ack),
        .done_o  (done),
        .err_o   (err)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int k = 0;

    // Model: a transfer is a record of when it was accepted and the edge on which it must complete.
    bit            m_busy = 0;
    bit            m_req = 0;
    bit            m_err = 0;
    bit            m_done = 0;
    logic [DW-1:0] m_data = '0;
    int            m_acc = 0;
    int            m_done_at = NEVER;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    task automatic check_all();
        check("ready", 32'(ready), 32'(!m_busy));
        check("req",   32'(req),   32'(m_req));
        check("data",  32'(dout),  32'(m_data));
        check("done",  32'(done),  32'(m_done));
        check("err",   32'(err),   32'(m_err));
    endtask

    // Called at a negedge; the ack toggle issued here is first sampled at the next edge and
    // completion lands two edges after that sampling edge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input bit do_ack);
        valid = v;
        din   = d;
        if (do_ack && m_busy && !loop_en && m_done_at == NEVER) begin
            ack_man   = m_req;
            m_done_at = k + 3;
        end
        @(posedge clk);
        k++;
        m_done = 0;
        if (m_busy) begin
            if (k - m_acc == TO) m_err = 1;
            if (k == m_done_at) begin
                m_busy = 0;
                m_done = 1;
            end
        end else if (v) begin
            m_busy    = 1;
            m_acc     = k;
            m_req     = ~m_req;
            m_data    = d;
            m_done_at = loop_en ? k + 3 : NEVER;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        valid = 1'b0;
        rst   = 1'b1;
        #1;
        m_busy = 0; m_req = 0; m_err = 0; m_done = 0; m_data = '0; m_done_at = NEVER;
        check_all();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++)
            cyc($urandom_range(0, 9) < 7, DW'($urandom), m_busy && (k - m_acc >= 5 || $urandom_range(0, 2) == 0));
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        // loopback single word, then back-to-back stream
        loop_en = 1'b1;
        cyc(1'b1, 8'hA5, 0);
        repeat (4) cyc(1'b0, 8'h00, 0);
        for (int j = 0; j < 9; j++) cyc(1'b1, DW'(j / 3 + 1), 0);
        repeat (3) cyc(1'b0, 8'h00, 0);
        // manual ack while valid keeps presenting changing words
        ack_man = m_req;
        loop_en = 1'b0;
        cyc(1'b1, 8'h3C, 0);
        for (int j = 0; j < 4; j++) cyc(1'b1, DW'($urandom), 0);
        cyc(1'b1, DW'($urandom), 1);
        repeat (4) cyc(1'b0, 8'h00, 0);
        rand_run(300);
        repeat (8) cyc(1'b0, 8'h00, 1);
        // timeout: ack withheld past TIMEOUT_CYC, then a late ack still completes
        cyc(1'b1, 8'hC3, 0);
        for (int j = 0; j < 19; j++) cyc($urandom_range(0, 1) == 1, DW'($urandom), 0);
        cyc(1'b0, 8'h00, 1);
        repeat (5) cyc(1'b0, 8'h00, 0);
        rand_run(60);
        repeat (8) cyc(1'b0, 8'h00, 1);
        // reset while waiting with an ack outstanding, then a stray ack toggle
        cyc(1'b1, 8'h77, 0);
        repeat (2) cyc(1'b0, 8'h00, 0);
        do_reset();
        ack_man = ~ack_man;
        repeat (5) cyc(1'b0, 8'h00, 0);
        ack_man = 1'b0;
        repeat (4) cyc(1'b0, 8'h00, 0);
        rand_run(150);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
